// File: rtl/noc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : noc_pkg
// Brief  : Shared router types: flit format, port indices and controller state.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package noc_pkg;

   localparam int FLIT_W    = 17;
   localparam int COORD_W   = 4;
   localparam int NUM_PORTS = 5;
   localparam int PORT_W    = 3;

   localparam logic [PORT_W-1:0] P_LOCAL = 3'd0;
   localparam logic [PORT_W-1:0] P_NORTH = 3'd1;
   localparam logic [PORT_W-1:0] P_EAST  = 3'd2;
   localparam logic [PORT_W-1:0] P_SOUTH = 3'd3;
   localparam logic [PORT_W-1:0] P_WEST  = 3'd4;

   typedef enum logic [1:0] {
      SINGLE = 2'b00,
      HEAD   = 2'b01,
      BODY   = 2'b10,
      TAIL   = 2'b11
   } flit_type_e;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } ctrl_state_e;

   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] p);
      logic [NUM_PORTS-1:0] one;
      one = {{(NUM_PORTS-1){1'b0}}, 1'b1};
      return one << p;
   endfunction

   function automatic logic opens_packet(input flit_type_e t);
      return (t == SINGLE) || (t == HEAD);
   endfunction

   function automatic logic closes_packet(input flit_type_e t);
      return (t == SINGLE) || (t == TAIL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/input_port_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : input_port_controller_if
// Brief  : Buffer-front, allocator and flow-control signals of one input port.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface input_port_controller_if;
   import noc_pkg::*;

   logic                 receive_i;
   logic [FLIT_W-1:0]    head_data_i;
   logic                 send_o;
   logic [NUM_PORTS-1:0] req_o;
   logic [NUM_PORTS-1:0] grant_i;
   logic [FLIT_W-1:0]    flit_o;
   logic                 flit_valid_o;
   logic                 full_o;
   logic                 empty_o;
   logic                 drop_o;
   logic                 overflow_o;

   modport slave (
      input  receive_i, head_data_i, grant_i,
      output send_o, req_o, flit_o, flit_valid_o,
             full_o, empty_o, drop_o, overflow_o
   );

   modport master (
      output receive_i, head_data_i, grant_i,
      input  send_o, req_o, flit_o, flit_valid_o,
             full_o, empty_o, drop_o, overflow_o
   );

endinterface
`default_nettype wire

// File: rtl/xy_route_compute.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : xy_route_compute
// Brief  : Dimension-ordered (X then Y) output-port selection for a head flit.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module xy_route_compute
   import noc_pkg::*;
#(
   parameter int X_COORD = 0,
   parameter int Y_COORD = 0
) (
   input  wire logic [COORD_W-1:0] dest_x,
   input  wire logic [COORD_W-1:0] dest_y,
   output logic      [PORT_W-1:0]  port
);

   localparam logic [COORD_W-1:0] c_x = COORD_W'(X_COORD);
   localparam logic [COORD_W-1:0] c_y = COORD_W'(Y_COORD);

   always_comb begin
      port = P_LOCAL;
      if (dest_x > c_x)
         port = P_EAST;
      else if (dest_x < c_x)
         port = P_WEST;
      else if (dest_y > c_y)
         port = P_NORTH;
      else if (dest_y < c_y)
         port = P_SOUTH;
   end

endmodule
`default_nettype wire

// File: rtl/input_port_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : input_port_controller
// Brief  : Tracks buffer occupancy, routes head flits and holds one output port per packet.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module input_port_controller
   import noc_pkg::*;
#(
   parameter int X_COORD = 0,
   parameter int Y_COORD = 0,
   parameter int DEPTH   = 5,
   parameter int CNT_W   = 3
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input_port_controller_if.slave port_if
);

   localparam logic [0:0]       c_st_idle   = ST_IDLE;
   localparam logic [0:0]       c_st_active = ST_ACTIVE;
   localparam logic [CNT_W-1:0] c_depth     = CNT_W'(DEPTH);

   logic [0:0]           r_state;
   logic [PORT_W-1:0]    r_port;
   logic [CNT_W-1:0]     r_cnt;

   flit_type_e           w_type;
   logic [PORT_W-1:0]    w_route;
   logic                 w_valid;
   logic                 w_full;
   logic                 w_idle;
   logic                 w_drop;
   logic                 w_send;
   logic                 w_inc;
   logic [NUM_PORTS-1:0] w_req;

   assign w_type  = flit_type_e'(port_if.head_data_i[FLIT_W-1:FLIT_W-2]);
   assign w_valid = (r_cnt != '0);
   assign w_full  = (r_cnt == c_depth);
   assign w_idle  = (r_state == c_st_idle);

   xy_route_compute #(
      .X_COORD (X_COORD),
      .Y_COORD (Y_COORD)
   ) u_route (
      .dest_x (port_if.head_data_i[7:4]),
      .dest_y (port_if.head_data_i[3:0]),
      .port   (w_route)
   );

   // Request stays up through empty gaps so the allocator keeps the wormhole path.
   always_comb begin
      w_req  = '0;
      w_drop = 1'b0;
      w_send = 1'b0;
      if (w_idle) begin
         w_drop = w_valid & ~opens_packet(w_type);
         w_send = w_drop;
      end else begin
         w_req  = port_onehot(r_port);
         w_send = w_valid & (|(w_req & port_if.grant_i));
      end
   end

   // A pop frees a slot in the same cycle, so a write into a full buffer still lands.
   assign w_inc = port_if.receive_i & (~w_full | w_send);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, w_inc} - {{(CNT_W-1){1'b0}}, w_send};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
         r_port  <= P_LOCAL;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_valid && opens_packet(w_type)) begin
                  r_state <= c_st_active;
                  r_port  <= w_route;
               end
            end
            c_st_active: begin
               if (w_send && closes_packet(w_type))
                  r_state <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign port_if.send_o       = w_send;
   assign port_if.req_o        = w_req;
   assign port_if.flit_o       = port_if.head_data_i;
   assign port_if.flit_valid_o = w_send;
   assign port_if.full_o       = w_full;
   assign port_if.empty_o      = ~w_valid;
   assign port_if.drop_o       = w_drop;
   assign port_if.overflow_o   = port_if.receive_i & w_full & ~w_send;

endmodule
`default_nettype wire

// File: tb/tb_input_port_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_input_port_controller
// Brief  : Directed bench for input_port_controller at router (1,1) with a buffer model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_input_port_controller;
   import noc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        receive = 1'b0;
   logic [16:0] wr_data = '0;
   logic [4:0]  grant = '0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   input_port_controller_if pif ();

   input_port_controller #(
      .X_COORD (1),
      .Y_COORD (1),
      .DEPTH   (5),
      .CNT_W   (3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .port_if (pif)
   );

   // buffer_storage stand-in: accepts a write when not full or when popping
   logic [16:0] fmem [0:7];
   logic [2:0]  frd = '0;
   logic [2:0]  fwr = '0;
   logic [3:0]  fcnt = '0;
   wire         f_pop  = pif.send_o;
   wire         f_push = receive & ((fcnt < 4'd5) | f_pop);

   assign pif.receive_i   = receive;
   assign pif.grant_i     = grant;
   assign pif.head_data_i = fmem[frd];

   always @(posedge clk) begin
      if (rst) begin
         frd  <= '0;
         fwr  <= '0;
         fcnt <= '0;
      end else begin
         if (f_pop) frd <= frd + 3'd1;
         if (f_push) begin
            fmem[fwr] <= wr_data;
            fwr       <= fwr + 3'd1;
         end
         fcnt <= fcnt + {3'd0, f_push} - {3'd0, f_pop};
      end
   end

   task automatic cyc(input logic r, input logic [16:0] d, input logic [4:0] g);
      @(negedge clk);
      receive = r;
      wr_data = d;
      grant   = g;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cyc(1'b1, 17'h08011, 5'b00000);
      cyc(1'b1, 17'h08011, 5'b00000);
      checks++;
      if (pif.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", pif.empty_o); end
      checks++;
      if (pif.req_o !== 5'b00000) begin errors++; $display("FAIL reset_req got=%b exp=00000", pif.req_o); end
      checks++;
      if ({pif.send_o, pif.flit_valid_o, pif.full_o, pif.drop_o, pif.overflow_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=00000",
                  {pif.send_o, pif.flit_valid_o, pif.full_o, pif.drop_o, pif.overflow_o});
      end
      @(negedge clk);
      rst     = 1'b0;
      receive = 1'b0;
   endtask

   task automatic test_single;
      cyc(1'b1, 17'h00021, 5'b00000);
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.req_o !== 5'b00000 || pif.empty_o !== 1'b0) begin
         errors++; $display("FAIL single_n1 req=%b empty=%b exp req=00000 empty=0", pif.req_o, pif.empty_o);
      end
      cyc(1'b0, 17'h0, 5'b00100);
      checks++;
      if (pif.req_o !== 5'b00100) begin errors++; $display("FAIL single_req got=%b exp=00100", pif.req_o); end
      checks++;
      if (pif.send_o !== 1'b1 || pif.flit_valid_o !== 1'b1 || pif.flit_o !== 17'h00021) begin
         errors++; $display("FAIL single_send send=%b valid=%b flit=%h exp 1 1 00021",
                            pif.send_o, pif.flit_valid_o, pif.flit_o);
      end
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.req_o !== 5'b00000 || pif.empty_o !== 1'b1) begin
         errors++; $display("FAIL single_idle req=%b empty=%b exp 00000 1", pif.req_o, pif.empty_o);
      end
   endtask

   task automatic test_routes;
      logic [16:0] flit [0:1];
      logic [4:0]  port [0:1];
      flit[0] = 17'h00001; port[0] = 5'b10000;   // dX=0 -> West
      flit[1] = 17'h00013; port[1] = 5'b00010;   // dX=1,dY=3 -> North
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, flit[i], 5'b00000);
         cyc(1'b0, 17'h0, 5'b00000);
         cyc(1'b0, 17'h0, port[i]);
         checks++;
         if (pif.req_o !== port[i] || pif.send_o !== 1'b1) begin
            errors++; $display("FAIL route_%0d req=%b send=%b exp %b 1", i, pif.req_o, pif.send_o, port[i]);
         end
      end
      cyc(1'b0, 17'h0, 5'b00000);
   endtask

   task automatic test_packet;
      logic [16:0] pk [0:3];
      logic [4:0]  g [0:5];
      logic        exp_send [0:5];
      int          k;
      pk[0] = 17'h08010; pk[1] = 17'h100AA; pk[2] = 17'h100BB; pk[3] = 17'h180CC;
      g[0] = 5'b01000; g[1] = 5'b00000; g[2] = 5'b01000; g[3] = 5'b10101; g[4] = 5'b01000; g[5] = 5'b01000;
      exp_send[0] = 1; exp_send[1] = 0; exp_send[2] = 1; exp_send[3] = 0; exp_send[4] = 1; exp_send[5] = 1;
      for (int i = 0; i < 4; i++) cyc(1'b1, pk[i], 5'b00000);
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.req_o !== 5'b01000 || pif.send_o !== 1'b0) begin
         errors++; $display("FAIL packet_wait req=%b send=%b exp 01000 0", pif.req_o, pif.send_o);
      end
      k = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 17'h0, g[i]);
         checks++;
         if (pif.req_o !== 5'b01000 || pif.send_o !== exp_send[i] ||
             (exp_send[i] && pif.flit_o !== pk[k])) begin
            errors++; $display("FAIL packet_step%0d req=%b send=%b flit=%h exp 01000 %b %h",
                               i, pif.req_o, pif.send_o, pif.flit_o, exp_send[i], pk[k]);
         end
         if (exp_send[i]) k++;
      end
      cyc(1'b0, 17'h0, 5'b01000);
      checks++;
      if (pif.req_o !== 5'b00000 || pif.empty_o !== 1'b1 || pif.send_o !== 1'b0) begin
         errors++; $display("FAIL packet_idle req=%b empty=%b send=%b exp 00000 1 0",
                            pif.req_o, pif.empty_o, pif.send_o);
      end
      grant = 5'b00000;
   endtask

   task automatic test_full;
      cyc(1'b1, 17'h08011, 5'b00000);
      for (int i = 0; i < 4; i++) cyc(1'b1, 17'h10000 | 17'(i), 5'b00000);
      cyc(1'b1, 17'h1FFFF, 5'b00000);
      checks++;
      if (pif.full_o !== 1'b1 || pif.overflow_o !== 1'b1) begin
         errors++; $display("FAIL full_overflow full=%b ovf=%b exp 1 1", pif.full_o, pif.overflow_o);
      end
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.full_o !== 1'b1 || pif.overflow_o !== 1'b0 || pif.req_o !== 5'b00001) begin
         errors++; $display("FAIL full_hold full=%b ovf=%b req=%b exp 1 0 00001",
                            pif.full_o, pif.overflow_o, pif.req_o);
      end
      cyc(1'b1, 17'h18000, 5'b00001);
      checks++;
      if (pif.send_o !== 1'b1 || pif.overflow_o !== 1'b0 || pif.flit_o !== 17'h08011) begin
         errors++; $display("FAIL full_rw send=%b ovf=%b flit=%h exp 1 0 08011",
                            pif.send_o, pif.overflow_o, pif.flit_o);
      end
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.full_o !== 1'b1) begin errors++; $display("FAIL full_after_rw got=%b exp=1", pif.full_o); end
      for (int i = 0; i < 5; i++) cyc(1'b0, 17'h0, 5'b00001);
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.empty_o !== 1'b1 || pif.req_o !== 5'b00000) begin
         errors++; $display("FAIL full_drain empty=%b req=%b exp 1 00000", pif.empty_o, pif.req_o);
      end
   endtask

   task automatic test_drop;
      cyc(1'b1, 17'h10055, 5'b00000);
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.send_o !== 1'b1 || pif.drop_o !== 1'b1 || pif.req_o !== 5'b00000 || pif.flit_o !== 17'h10055) begin
         errors++; $display("FAIL drop_pulse send=%b drop=%b req=%b flit=%h exp 1 1 00000 10055",
                            pif.send_o, pif.drop_o, pif.req_o, pif.flit_o);
      end
      cyc(1'b0, 17'h0, 5'b00000);
      checks++;
      if (pif.empty_o !== 1'b1 || pif.drop_o !== 1'b0 || pif.send_o !== 1'b0) begin
         errors++; $display("FAIL drop_after empty=%b drop=%b send=%b exp 1 0 0",
                            pif.empty_o, pif.drop_o, pif.send_o);
      end
   endtask

   task automatic test_wrong_port_reset;
      cyc(1'b1, 17'h08011, 5'b00000);
      cyc(1'b1, 17'h100EE, 5'b00000);
      cyc(1'b0, 17'h0, 5'b00010);
      checks++;
      if (pif.req_o !== 5'b00001 || pif.send_o !== 1'b0) begin
         errors++; $display("FAIL wrong_port req=%b send=%b exp 00001 0", pif.req_o, pif.send_o);
      end
      rst = 1'b1;
      cyc(1'b0, 17'h0, 5'b00000);
      rst = 1'b0;
      cyc(1'b0, 17'h0, 5'b00001);
      checks++;
      if (pif.req_o !== 5'b00000 || pif.empty_o !== 1'b1 || pif.send_o !== 1'b0) begin
         errors++; $display("FAIL mid_reset req=%b empty=%b send=%b exp 00000 1 0",
                            pif.req_o, pif.empty_o, pif.send_o);
      end
      grant = 5'b00000;
   endtask

   initial begin
      test_reset();
      test_single();
      test_routes();
      test_packet();
      test_full();
      test_drop();
      test_wrong_port_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
